// File: rtl/spi_frame_ctrl_pkg.sv
// Shared constants for the SPI frame controller: register map, command-byte
// layout, FSM encoding and the command validity check.
package spi_frame_ctrl_pkg;

  localparam int REG_R      = 0;
  localparam int REG_G      = 1;
  localparam int REG_B      = 2;
  localparam int REG_W      = 3;
  localparam int REG_MODE   = 4;
  localparam int REG_BRIGHT = 5;

  localparam logic [3:0] SYNC_DEFAULT = 4'b0101;

  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_SYNC_MSB  = 6;
  localparam int CMD_SYNC_LSB  = 3;
  localparam int CMD_IDX_MSB   = 2;
  localparam int CMD_IDX_LSB   = 0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  // A command is accepted only as a write with matching sync and an in-range index.
  function automatic logic cmd_ok(input logic [7:0] cmd, input logic [3:0] sync,
                                  input int num_regs);
    cmd_ok = cmd[CMD_WRITE_BIT]
          && (cmd[CMD_SYNC_MSB:CMD_SYNC_LSB] == sync)
          && (32'(cmd[CMD_IDX_MSB:CMD_IDX_LSB]) < 32'(num_regs));
  endfunction

endpackage

// File: rtl/spi_frame_ctrl_regfile.sv
// Shadow and live configuration registers; the shadow collects a frame's
// writes and is copied into the live set in a single cycle on commit.
module cfg_regfile
  import spi_frame_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [2:0]            addr,
  input  logic [7:0]            wdata,
  input  logic                  load_shadow,
  input  logic                  commit,
  output logic [8*NUM_REGS-1:0] cfg_bus
);

  logic [7:0] shadow_r [NUM_REGS];
  logic [7:0] live_r   [NUM_REGS];

  // Shadow tracks live at frame start, then takes byte writes; live moves only on commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_r[k] <= 8'd0;
        live_r[k]   <= 8'd0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (load_shadow) begin
          shadow_r[k] <= live_r[k];
        end else if (we && (addr == 3'(k))) begin
          shadow_r[k] <= wdata;
        end else begin
          shadow_r[k] <= shadow_r[k];
        end
        if (commit) begin
          live_r[k] <= shadow_r[k];
        end else begin
          live_r[k] <= live_r[k];
        end
      end
    end
  end

  // Flatten the live registers onto the bus, reg k in byte lane k.
  always_comb begin
    cfg_bus = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      cfg_bus[8*k +: 8] = live_r[k];
    end
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// Frame-level SPI controller: parses a command byte plus data bytes per
// chip-select frame and commits them atomically to the live register bus.
module spi_frame_ctrl
  import spi_frame_ctrl_pkg::*;
#(
  parameter int         NUM_REGS = 6,
  parameter logic [3:0] SYNC     = SYNC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_n,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic [8*NUM_REGS-1:0] cfg_bus,
  output logic                  cfg_update,
  output logic                  frame_err,
  output logic                  busy
);

  localparam logic [2:0] LAST_PTR = 3'(NUM_REGS - 1);

  logic [2:0] state_r;
  logic [2:0] state_s;
  logic [2:0] ptr_r;
  logic [2:0] ptr_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_s;
  logic [7:0] cnt_inc_s;
  logic       we_s;
  logic       load_s;
  logic       commit_s;
  logic       err_s;

  // Next-state logic; in DATA the byte is counted before the close rule looks at cnt.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    cnt_s     = cnt_r;
    we_s      = 1'b0;
    load_s    = 1'b0;
    commit_s  = 1'b0;
    err_s     = 1'b0;
    cnt_inc_s = (cnt_r == 8'hFF) ? 8'hFF : cnt_r + 8'd1;
    case (state_r)
      ST_IDLE: begin
        if (!cs_n) begin
          state_s = ST_CMD;
          load_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (byte_valid) begin
          if (cmd_ok(byte_data, SYNC, NUM_REGS)) begin
            state_s = ST_DATA;
            ptr_s   = byte_data[CMD_IDX_MSB:CMD_IDX_LSB];
            cnt_s   = 8'd0;
          end else begin
            state_s = ST_DRAIN;
            err_s   = 1'b1;
          end
        end else if (cs_n) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CMD;
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          we_s  = 1'b1;
          ptr_s = (ptr_r == LAST_PTR) ? 3'd0 : ptr_r + 3'd1;
          cnt_s = cnt_inc_s;
        end else begin
          we_s  = 1'b0;
        end
        if (cs_n) begin
          state_s = (cnt_s != 8'd0) ? ST_COMMIT : ST_IDLE;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_DRAIN: begin
        if (cs_n) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_COMMIT: begin
        commit_s = 1'b1;
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, pointer, counter and the registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 3'd0;
      cnt_r      <= 8'd0;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      cnt_r      <= cnt_s;
      cfg_update <= commit_s;
      frame_err  <= err_s;
      busy       <= (state_s != ST_IDLE);
    end
  end

  cfg_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk         (clk),
    .reset       (reset),
    .we          (we_s),
    .addr        (ptr_r),
    .wdata       (byte_data),
    .load_shadow (load_s),
    .commit      (commit_s),
    .cfg_bus     (cfg_bus)
  );

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl: stimulus queues expected pulses,
// a negedge monitor pops and compares them as the DUT raises them.
module tb_spi_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [47:0] cfg_bus;
  logic        cfg_update;
  logic        frame_err;
  logic        busy;

  spi_frame_ctrl #(.NUM_REGS(6), .SYNC(4'b0101)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs_n       (cs_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .cfg_bus    (cfg_bus),
    .cfg_update (cfg_update),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 = cfg_update with bus value, 2 = frame_err
  typedef struct {
    int          kind;
    logic [47:0] bus;
    int          cyc;
  } ev_t;

  ev_t        sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] fb [8];

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    int  act_kind;
    if (cfg_update || frame_err) begin
      act_kind = (cfg_update && frame_err) ? 3 : (cfg_update ? 1 : 2);
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected no pulse", act_kind, cyc);
      end else begin
        e = sb.pop_front();
        if (act_kind != e.kind || cyc != e.cyc || (e.kind == 1 && cfg_bus !== e.bus)) begin
          fails++;
          $display("FAIL pulse_check: got kind %0d cycle %0d bus %h, expected kind %0d cycle %0d bus %h",
                   act_kind, cyc, cfg_bus, e.kind, e.cyc, e.bus);
        end
      end
    end
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [47:0] bus, input int at);
    ev_t e;
    e.kind = kind;
    e.bus  = bus;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  // Drive one frame from fb[0..n-1]; kind 0 none, 1 update, 2 error.
  task automatic run_frame(input string name, input int n, input bit close_last,
                           input int kind, input logic [47:0] exp_bus, input int gap);
    @(posedge clk); #1 cs_n = 1'b0;
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      byte_valid = 1'b1;
      byte_data  = fb[i];
      if (i == 0 && kind == 2) expect_ev(2, 48'h0, cyc + 1);
      if (i == n - 1 && close_last) begin
        cs_n = 1'b1;
        if (kind == 1) expect_ev(1, exp_bus, cyc + 2);
      end
    end
    if (close_last) begin
      @(posedge clk); #1 byte_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      byte_valid = 1'b0;
      cs_n       = 1'b1;
      if (kind == 1) expect_ev(1, exp_bus, cyc + 2);
    end
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
      check({name, "_bus"}, cfg_bus, exp_bus);
      check({name, "_busy"}, 48'(busy), 48'd0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    cs_n       = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bus", cfg_bus, 48'h0);
    check("reset_flags", {45'd0, cfg_update, frame_err, busy}, 48'h0);
    reset = 1'b0;

    fb = '{8'hA8, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00};
    run_frame("basic", 5, 1'b0, 1, 48'h0000_4433_2211, 4);

    fb = '{8'hAC, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("partial", 2, 1'b0, 1, 48'h007F_4433_2211, 4);

    fb = '{8'hB0, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("bad_sync", 2, 1'b0, 2, 48'h007F_4433_2211, 4);

    fb = '{8'h28, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("read_cmd", 2, 1'b0, 2, 48'h007F_4433_2211, 4);

    fb = '{8'hAE, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("bad_index", 2, 1'b0, 2, 48'h007F_4433_2211, 4);

    fb = '{8'hA9, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("after_err", 2, 1'b0, 1, 48'h007F_4433_9911, 4);

    fb = '{8'hAD, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00};
    run_frame("wrap", 5, 1'b0, 1, 48'h017F_4404_0302, 4);

    fb = '{8'hA8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("cmd_only", 1, 1'b0, 0, 48'h017F_4404_0302, 4);
    run_frame("empty", 0, 1'b0, 0, 48'h017F_4404_0302, 4);

    fb = '{8'hAB, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("close_with_byte", 2, 1'b1, 1, 48'h017F_5A04_0302, 4);

    fb = '{8'hA8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    run_frame("overrun", 8, 1'b0, 1, 48'h0605_0403_0207, 4);

    // Reset in the middle of a frame after two data bytes.
    @(posedge clk); #1 cs_n = 1'b0;
    @(posedge clk);
    fb = '{8'hA8, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      byte_valid = 1'b1;
      byte_data  = fb[i];
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    check("mid_frame_busy", 48'(busy), 48'd1);
    reset = 1'b1;
    cs_n  = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_reset_bus", cfg_bus, 48'h0);
    check("mid_reset_busy", 48'(busy), 48'd0);
    repeat (3) @(posedge clk);

    fb = '{8'hA8, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("post_reset", 2, 1'b0, 1, 48'h0000_0000_00AA, 4);

    // Second frame starts while the first is committing.
    fb = '{8'hA8, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("b2b_first", 2, 1'b0, 1, 48'h0000_0000_0010, 0);
    fb = '{8'hA9, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("b2b_second", 2, 1'b0, 1, 48'h0000_0000_2010, 4);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 48'(sb.size()), 48'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
